// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature step decoder: FSM states, Gray phase codes, forward successor.
// Optional glitch filter is selected with QDEC_GLITCH_FILTER_EN (see qdec_input_cond).
package qdec_pkg;

    typedef enum logic {
        S_INIT,
        S_RUN
    } qdec_state_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    // Forward (up) rotation is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] next_fwd(input logic [1:0] ph);
        logic [1:0] nxt;
        unique case (ph)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/qdec_input_cond.sv
// Per-bit input conditioning: 2-flop synchroniser, plus a FILTER_LEN-sample
// agreement filter when QDEC_GLITCH_FILTER_EN is defined.
module qdec_input_cond #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta;
    logic sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
        end
    end

`ifdef QDEC_GLITCH_FILTER_EN
    logic [FILTER_LEN-2:0] hist;
    logic                  filt_q;
    logic [FILTER_LEN-1:0] window;
    logic                  all_eq;

    if (FILTER_LEN > 2) begin : g_hist_long
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) hist <= '0;
            else        hist <= {hist[FILTER_LEN-3:0], sync};
        end
    end else begin : g_hist_short
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) hist <= '0;
            else        hist <= sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) filt_q <= 1'b0;
        else        filt_q <= dout;
    end

    // Window includes the live synchronised sample so acceptance costs FILTER_LEN-1 extra cycles.
    always_comb begin
        window = {hist, sync};
        all_eq = (&window) | ~(|window);
        dout   = all_eq ? sync : filt_q;
    end
`else
    assign dout = sync;
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: step/direction pulses, wrapping position, saturating error count.
// Define QDEC_GLITCH_FILTER_EN to enable the FILTER_LEN-sample input glitch filter.
module quad_step_decoder
    import qdec_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned ERR_W      = 8,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             enable,
    input  logic             clear,
    output logic             step,
    output logic             up_down,
    output logic             err,
    output logic [WIDTH-1:0] position,
    output logic [ERR_W-1:0] err_cnt
);

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int unsigned INIT_LEN = 2 + FILTER_LEN;
`else
    localparam int unsigned INIT_LEN = 2;
`endif
    localparam int unsigned CNT_W = $clog2(INIT_LEN + 1);

    logic a_s;
    logic b_s;
    logic [1:0] ph;

    qdec_input_cond #(.FILTER_LEN(FILTER_LEN)) u_cond_a (
        .clk   (clk),
        .rst_n (reset),
        .din   (a),
        .dout  (a_s)
    );

    qdec_input_cond #(.FILTER_LEN(FILTER_LEN)) u_cond_b (
        .clk   (clk),
        .rst_n (reset),
        .din   (b),
        .dout  (b_s)
    );

    assign ph = {a_s, b_s};

    qdec_state_t      state_q, state_d;
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic [1:0]       prev_ph_q, prev_ph_d;
    logic             step_d, err_d, up_down_d;
    logic [WIDTH-1:0] position_d;
    logic [ERR_W-1:0] err_cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            prev_ph_q  <= PH_00;
            step       <= 1'b0;
            err        <= 1'b0;
            up_down    <= 1'b1;
            position   <= '0;
            err_cnt    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_ph_q  <= prev_ph_d;
            step       <= step_d;
            err        <= err_d;
            up_down    <= up_down_d;
            position   <= position_d;
            err_cnt    <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_ph_d  = prev_ph_q;
        step_d     = 1'b0;
        err_d      = 1'b0;
        up_down_d  = up_down;
        position_d = position;
        err_cnt_d  = err_cnt;

        unique case (state_q)
            S_INIT: begin
                if (init_cnt_q == CNT_W'(INIT_LEN)) begin
                    prev_ph_d = ph;
                    state_d   = S_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                // Reference tracks the phase even while disabled, so re-enabling is step-free.
                prev_ph_d = ph;
                if (enable && (ph != prev_ph_q)) begin
                    if (ph == next_fwd(prev_ph_q)) begin
                        step_d     = 1'b1;
                        up_down_d  = 1'b1;
                        position_d = position + WIDTH'(1);
                    end else if (prev_ph_q == next_fwd(ph)) begin
                        step_d     = 1'b1;
                        up_down_d  = 1'b0;
                        position_d = position - WIDTH'(1);
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt != '1) err_cnt_d = err_cnt + ERR_W'(1);
                    end
                end
            end
        endcase

        if (clear) begin
            position_d = '0;
            err_cnt_d  = '0;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder against a phase-history reference model.
// Honours QDEC_GLITCH_FILTER_EN to match the filtered build.
module tb_quad_step_decoder;
    import qdec_pkg::*;

    localparam int WIDTH      = 4;
    localparam int ERR_W      = 8;
    localparam int FILTER_LEN = 3;
`ifdef QDEC_GLITCH_FILTER_EN
    localparam int FLM      = FILTER_LEN;
    localparam int INIT_LEN = 2 + FILTER_LEN;
`else
    localparam int FLM      = 1;
    localparam int INIT_LEN = 2;
`endif
    localparam int LAT   = 2 + FLM;
    localparam int MAXP  = 1 << WIDTH;
    localparam int MAXE  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset, a, b, enable, clear;
    logic             step, up_down, err;
    logic [WIDTH-1:0] position;
    logic [ERR_W-1:0] err_cnt;

    quad_step_decoder #(.WIDTH(WIDTH), .ERR_W(ERR_W), .FILTER_LEN(FILTER_LEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .enable   (enable),
        .clear    (clear),
        .step     (step),
        .up_down  (up_down),
        .err      (err),
        .position (position),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: pin samples per clock edge, per-bit filtered phase, counters.
    int         edge_n;
    logic [1:0] pin_r [16];
    logic [1:0] fph_r [16];
    int         m_pos, m_ecnt;
    int         m_ud, m_step, m_err;
    int         steps_seen, errs_seen;

    function automatic logic [1:0] pin_at(input int j);
        return (j <= 0) ? 2'b00 : pin_r[j % 16];
    endfunction

    function automatic logic [1:0] fph_at(input int j);
        return (j <= 0) ? 2'b00 : fph_r[j % 16];
    endfunction

    // Angular position of a phase on the quadrature circle.
    function automatic int gidx(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] prev_of(input logic [1:0] x);
        logic [1:0] r;
        r = 2'b00;
        for (int p = 0; p < 4; p++) if (next_fwd(2'(p)) == x) r = 2'(p);
        return r;
    endfunction

    task automatic model_reset();
        edge_n = 0;
        m_pos  = 0;
        m_ecnt = 0;
        m_ud   = 1;
    endtask

    task automatic cycle();
        logic [1:0] p, pv, fprev, f, old_ph, cur_ph;
        int         en, clr, d;
        bit         same;
        @(posedge clk);
        edge_n++;
        p   = {a, b};
        en  = enable;
        clr = clear;
        pin_r[edge_n % 16] = p;
        fprev = fph_at(edge_n - 1);
        for (int bi = 0; bi < 2; bi++) begin
            same = 1'b1;
            for (int k = 1; k < FLM; k++) begin
                pv = pin_at(edge_n - k);
                if (pv[bi] != p[bi]) same = 1'b0;
            end
            f[bi] = same ? p[bi] : fprev[bi];
        end
        fph_r[edge_n % 16] = f;
        m_step = 0;
        m_err  = 0;
        if (edge_n >= INIT_LEN + 2 && en != 0) begin
            old_ph = fph_at(edge_n - 3);
            cur_ph = fph_at(edge_n - 2);
            d = (gidx(cur_ph) - gidx(old_ph) + 4) % 4;
            if (d == 1) begin
                m_step = 1; m_ud = 1; m_pos = (m_pos + 1) % MAXP;
            end else if (d == 3) begin
                m_step = 1; m_ud = 0; m_pos = (m_pos + MAXP - 1) % MAXP;
            end else if (d == 2) begin
                m_err = 1; if (m_ecnt < MAXE) m_ecnt++;
            end
        end
        if (clr != 0) begin
            m_pos  = 0;
            m_ecnt = 0;
        end
        @(negedge clk);
        chk("step", step, m_step);
        chk("err", err, m_err);
        chk("up_down", up_down, m_ud);
        chk("position", position, m_pos);
        chk("err_cnt", err_cnt, m_ecnt);
        steps_seen += int'(step);
        errs_seen  += int'(err);
    endtask

    task automatic set_ph(input logic [1:0] p);
        {a, b} = p;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_up_down"}, up_down, 1);
        chk({tag, "_position"}, position, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1 chk_reset_outputs("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ph;
        int         lat;
        bit         got;
        int         hold;

        reset = 1'b0; a = 1'b1; b = 1'b1; enable = 1'b1; clear = 1'b0;
        steps_seen = 0; errs_seen = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b1;

        // Release with 11 held: no pulses while synchronisers fill.
        repeat (4) cycle();
        chk("init_quiet", steps_seen + errs_seen, 0);
        chk("init_pos", position, 0);
        chk("init_ud", up_down, 1);
        repeat (LAT) cycle();

        // 20 forward transitions, wrapping 15 -> 0.
        ph = 2'b11;
        steps_seen = 0;
        for (int i = 0; i < 20; i++) begin
            ph = next_fwd(ph);
            set_ph(ph);
            repeat (4) cycle();
        end
        repeat (LAT) cycle();
        chk("fwd_steps", steps_seen, 20);
        chk("fwd_pos", position, 4);
        chk("fwd_ud", up_down, 1);

        // Reverse from zero, with explicit latency measurement.
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ph = prev_of(ph);
            set_ph(ph);
            lat = 0;
            got = 1'b0;
            for (int c = 1; c <= 12 && !got; c++) begin
                cycle();
                if (step) begin got = 1'b1; lat = c; end
            end
            chk("rev_latency", lat, LAT);
            repeat (2) cycle();
        end
        chk("rev_pos", position, 13);
        chk("rev_ud", up_down, 0);

        // Illegal double-bit jumps until err_cnt saturates.
        steps_seen = 0; errs_seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                ph = next_fwd(ph);
                set_ph(ph);
                repeat (LAT + 1) cycle();
                ph = prev_of(ph);
                set_ph(ph);
                repeat (LAT + 1) cycle();
                steps_seen = 0;
            end
            ph = ~ph;
            set_ph(ph);
            repeat (FLM + 1) cycle();
        end
        repeat (LAT) cycle();
        chk("jump_errs", errs_seen, 300);
        chk("jump_steps", steps_seen, 0);
        chk("jump_err_sat", err_cnt, MAXE);
        chk("jump_pos", position, 13);

        // Motion while disabled, then re-enable without motion.
        enable = 1'b0;
        steps_seen = 0; errs_seen = 0;
        for (int i = 0; i < 5; i++) begin
            ph = next_fwd(ph);
            set_ph(ph);
            repeat (4) cycle();
        end
        repeat (LAT) cycle();
        enable = 1'b1;
        repeat (6) cycle();
        chk("dis_pulses", steps_seen + errs_seen, 0);
        chk("dis_pos", position, 13);

        // Clear coincident with a step pulse.
        ph = next_fwd(ph);
        set_ph(ph);
        repeat (LAT - 1) cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clr_step_pulse", step, 1);
        chk("clr_step_pos", position, 0);
        chk("clr_step_errcnt", err_cnt, 0);
        repeat (4) cycle();

`ifdef QDEC_GLITCH_FILTER_EN
        // Short glitch on a is absorbed; a held change is accepted at filtered latency.
        steps_seen = 0; errs_seen = 0;
        a = ~a;
        repeat (FILTER_LEN - 1) cycle();
        a = ~a;
        repeat (10) cycle();
        chk("glitch_pulses", steps_seen + errs_seen, 0);
        ph = next_fwd(ph);
        set_ph(ph);
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 12 && !got; c++) begin
            cycle();
            if (step) begin got = 1'b1; lat = c; end
        end
        chk("filt_latency", lat, 2 + FILTER_LEN);
        repeat (4) cycle();
`endif

        // Randomised segments with occasional clear, disable and mid-run resets.
        for (int seg = 0; seg < 300; seg++) begin
            if (seg == 100 || seg == 200) do_reset();
            ph     = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 29) == 0);
            hold   = $urandom_range(1, 5);
            set_ph(ph);
            repeat (hold) begin
                cycle();
                clear = 1'b0;
            end
        end
        enable = 1'b1;
        repeat (LAT + 2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Front end that drives the team's up/down position counter from a 2-phase quadrature source (A/B).
- Synchronises the raw A/B inputs and decodes Gray-code phase transitions into single-cycle step pulses and a direction flag (`up_down`, 1 = up).
- Keeps its own wrapping position count and a saturating error count for illegal transitions.

Parameters:
- WIDTH, 4, width of position output (matches the 4-bit counter).
- ERR_W, 8, width of saturating error counter.
- FILTER_LEN, 3, consecutive identical samples required by the optional glitch filter (min 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- a  input  1  quadrature phase A, asynchronous to clk.
- b  input  1  quadrature phase B, asynchronous to clk.
- enable  input  1  sync; 0 suppresses step/err/count updates.
- clear  input  1  sync; zeroes position and err_cnt.
- step  output  1  one-cycle pulse per valid phase transition.
- up_down  output  1  direction of last valid step; 1 = up.
- err  output  1  one-cycle pulse on illegal transition.
- position  output  WIDTH  signed-agnostic wrapping step count.
- err_cnt  output  ERR_W  saturating illegal-transition count.

Behaviour:
- Reset values (async on reset==0):
  - step=0, up_down=1, err=0, position=0, err_cnt=0.
  - Synchroniser flops=0, FSM=S_INIT.
- Input path:
  - a and b each pass through a 2-flop synchroniser.
  - The decoded phase is ph={a_s,b_s}.
- Forward (up) sequence: 00→01→11→10→00. Reverse is down.
- FSM S_INIT:
  - Stays for 2 cycles after reset release so the synchronisers fill.
  - Then loads prev_ph←ph and moves to S_RUN.
  - No step or err is issued in S_INIT.
- FSM S_RUN, evaluated every cycle:
  - ph==prev_ph: nothing.
  - One bit changed, forward: step=1, up_down←1, position+1.
  - One bit changed, reverse: step=1, up_down←0, position−1.
  - Both bits changed (00↔11, 01↔10): err=1, err_cnt+1 saturating at all-ones, no step, up_down and position unchanged.
  - prev_ph←ph in all cases.
- Latency: pin edge to step/err pulse is 3 clk (2 sync + 1 decode register), filter disabled. position and up_down update in the same cycle as the step pulse.
- Position arithmetic: modulo 2^WIDTH. Max+1 wraps to 0; 0−1 wraps to max.
- enable=0:
  - No step or err pulses; position and err_cnt hold.
  - prev_ph still tracks ph, so re-enabling never produces a spurious step.
- clear=1:
  - position←0, err_cnt←0 next edge.
  - clear wins over a simultaneous step or err for the counters.
  - step/err pulses and up_down still behave normally that cycle.
- Reset mid-operation: everything returns to reset values immediately. On release the FSM re-enters S_INIT, and the first phase sampled is taken as reference with no step.
- Outputs are fully registered; no combinational path from a/b/enable/clear to any output.

Optional Feature:
- Macro: QDEC_GLITCH_FILTER_EN.
- Defined:
  - Each synchronised phase bit is accepted only after FILTER_LEN consecutive identical samples.
  - Shorter pulses are ignored entirely, with no step and no err.
  - Latency becomes 3+FILTER_LEN−1 clk.
  - S_INIT extends by FILTER_LEN cycles.
- Undefined: filter absent; synchronised bits feed the decoder directly; latency 3 clk.

Decomposition:
- Package qdec_pkg:
  - FSM state encoding S_INIT/S_RUN.
  - Phase constants PH_00, PH_01, PH_11, PH_10.
  - Function next_fwd(ph) returning the forward successor, used by both RTL and bench model.
- Sub-module qdec_input_cond:
  - Per-bit 2-flop synchroniser plus the optional filter.
  - Instantiated twice (a, b).
- Decoder FSM and counters live in the top module.

Test Plan:
- Reset then release with a=1,b=1 held: no step/err for 4 cycles, then position=0, up_down=1.
- 20 forward transitions 00→01→11→10… each held 4 clk: 20 step pulses, up_down=1, position wraps 15→0 and ends at 4.
- Reverse 3 transitions from position 0: position=13, up_down=0; each step arrives exactly 3 clk after the pin edge.
- Jump 00→11 and 01→10 repeated 300 times: err pulses, no step, err_cnt saturates at 255, position unchanged.
- enable=0 during 5 forward transitions, then enable=1 with no motion: position unchanged, no pulse at re-enable. clear asserted in the same cycle as a step: position=0.
- With QDEC_GLITCH_FILTER_EN and FILTER_LEN=3: a 2-cycle glitch on a produces no step or err, and a 3+ cycle change produces one step at latency 5 clk. Async reset asserted mid-sequence clears all outputs within the same cycle.
